gpio_irq_controller: RTL and testbench
======================================

GPIO_IRQ_CONTROLLER -- requirements
Module: gpio_irq_controller

Interface
REQ-001 The block SHALL have parameter OUT_WIDTH, default 18, meaning the number of gpio_out bits (1..32).
REQ-002 The block SHALL have parameter IN_WIDTH, default 12, meaning the number of gpio_in bits (1..32).
REQ-003 The block SHALL have parameter BASE_PAGE, default 20'h00001, meaning the value data_addr[31:12] must match to decode.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth (>=2).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- data_req  in  1  bus request
- data_we  in  1  1 = write, 0 = read
- data_be  in  4  byte enables
- data_addr  in  32  byte address
- data_wdata  in  32  write data
- data_gnt  out  1  request accepted
- data_rvalid  out  1  response valid
- data_rdata  out  32  read data
- gpio_out  out  OUT_WIDTH  output pins
- gpio_in  in  IN_WIDTH  asynchronous input pins
- irq  out  1  level interrupt

Function
REQ-006 Decode SHALL be data_addr[31:12]==BASE_PAGE; register select SHALL be data_addr[11:2].
REQ-007 data_gnt SHALL register (data_req & decode & ~data_gnt), giving a 1-cycle grant pulse; back-to-back requests SHALL be granted on alternate cycles.
REQ-008 Each write SHALL commit exactly once, at the edge that sets data_gnt; each read SHALL capture data_rdata at that same edge.
REQ-009 data_rvalid SHALL be data_gnt delayed one cycle, for reads and writes alike; data_rdata SHALL hold its value until the next read is captured.
REQ-010 gpio_in SHALL pass through SYNC_STAGES flops before any use (sync_in).
REQ-011 Register map (word offsets):
- 0 IN, RO, sync_in
- 1 OUT, RW, byte-enabled write
- 2 OUT_SET, WO, gpio_out |= wdata
- 3 OUT_CLR, WO, gpio_out &= ~wdata
- 4 RISE_EN, RW
- 5 FALL_EN, RW
- 6 STATUS, RW1C
- 7 IRQ_EN, RW
REQ-012 Byte enables SHALL apply to every writable register; disabled bytes SHALL be unchanged, including for SET/CLR/W1C.
REQ-013 Bits at or above the register width SHALL read 0 and ignore writes; OUT bits are OUT_WIDTH wide, all others IN_WIDTH.
REQ-014 OUT_SET and OUT_CLR SHALL read 0; unmapped offsets SHALL read 0 and ignore writes, with normal gnt/rvalid.
REQ-015 A registered copy sync_prev SHALL track sync_in; rise = sync_in & ~sync_prev; fall = ~sync_in & sync_prev.
REQ-016 STATUS[i] SHALL set on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]) and stay set until cleared by a W1C.
REQ-017 When a W1C to STATUS[i] and a new edge on bit i occur at the same edge, the set SHALL win.
REQ-018 irq SHALL be |(STATUS & IRQ_EN), driven from flops only, with no combinational path from the bus.
REQ-019 Latency SHALL be: a pin change is visible in IN after SYNC_STAGES edges, and in STATUS/irq one edge later.
REQ-020 Requests with decode false SHALL produce no gnt and no state change.

Reset
REQ-021 On rst high, asynchronously and regardless of clk, all of the following SHALL be 0: data_gnt, data_rvalid, data_rdata, gpio_out, synchroniser flops, sync_prev, RISE_EN, FALL_EN, STATUS, IRQ_EN, irq.
REQ-022 A transaction in flight at reset SHALL be dropped, with no gnt or rvalid after release; the first request after release SHALL be handled normally.
REQ-023 Because enables reset to 0, no STATUS bit SHALL set after reset release until software enables it.

Verification
REQ-024 Write OUT=0x3FFFF with be=0b0101 -> gpio_out=0x300FF; read OUT -> rdata 0x000300FF; rvalid exactly 1 cycle after gnt.
REQ-025 OUT=0x00F0, then SET 0x000F, then CLR 0x0030 -> gpio_out=0x00CF; reads of offsets 2/3 return 0.
REQ-026 RISE_EN=0x1, IRQ_EN=0x1, toggle gpio_in[0] 0->1 -> STATUS=0x1 and irq=1 on edge SYNC_STAGES+1; W1C 0x1 -> irq=0.
REQ-027 W1C STATUS bit 0 at the same edge as a new rising edge on bit 0 -> STATUS[0] stays 1.
REQ-028 Hold data_req=1 for 6 cycles -> gnt pulses on cycles 1, 3, 5; assert rst mid-stream -> gnt/rvalid/gpio_out drop to 0 immediately without a clock edge.
REQ-029 Access with data_addr=0x00002004 -> no gnt; read of offset 0x020 -> rdata 0.

Source files
------------

// File: rtl/gpio_irq_controller.sv
// Memory-mapped GPIO block: byte-enabled output register with set/clear aliases,
// synchronised inputs with per-bit edge detection, sticky W1C status and a level irq.
module gpio_irq_controller #(
    parameter int          OUT_WIDTH   = 18,
    parameter int          IN_WIDTH    = 12,
    parameter logic [19:0] BASE_PAGE   = 20'h00001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [3:0]           data_be,
    input  logic [31:0]          data_addr,
    input  logic [31:0]          data_wdata,
    output logic                 data_gnt,
    output logic                 data_rvalid,
    output logic [31:0]          data_rdata,
    output logic [OUT_WIDTH-1:0] gpio_out,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic                 irq
);

    localparam logic [9:0] A_IN      = 10'd0;
    localparam logic [9:0] A_OUT     = 10'd1;
    localparam logic [9:0] A_SET     = 10'd2;
    localparam logic [9:0] A_CLR     = 10'd3;
    localparam logic [9:0] A_RISE    = 10'd4;
    localparam logic [9:0] A_FALL    = 10'd5;
    localparam logic [9:0] A_STATUS  = 10'd6;
    localparam logic [9:0] A_IRQ_EN  = 10'd7;

    logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] r_sync;
    logic [IN_WIDTH-1:0]  r_sync_prev;
    logic [IN_WIDTH-1:0]  r_rise_en;
    logic [IN_WIDTH-1:0]  r_fall_en;
    logic [IN_WIDTH-1:0]  r_status;
    logic [IN_WIDTH-1:0]  r_irq_en;
    logic [OUT_WIDTH-1:0] r_out;
    logic                 r_gnt;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;

    logic                 w_decode;
    logic                 w_accept;
    logic                 w_wr;
    logic                 w_rd;
    logic [9:0]           w_sel;
    logic [31:0]          w_bmask;
    logic [31:0]          w_wmask;
    logic [31:0]          w_rdata;
    logic [IN_WIDTH-1:0]  w_sync_in;
    logic [IN_WIDTH-1:0]  w_event;
    logic [IN_WIDTH-1:0]  w_status_nxt;
    logic                 w_unused;

    assign w_decode = (data_addr[31:12] == BASE_PAGE);
    assign w_sel    = data_addr[11:2];
    // Blocking on r_gnt forces a one-cycle gap between back-to-back grants.
    assign w_accept = data_req & w_decode & ~r_gnt;
    assign w_wr     = w_accept & data_we;
    assign w_rd     = w_accept & ~data_we;
    assign w_bmask  = {{8{data_be[3]}}, {8{data_be[2]}}, {8{data_be[1]}}, {8{data_be[0]}}};
    assign w_wmask  = data_wdata & w_bmask;
    assign w_unused = &{1'b0, data_addr[1:0]};

    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_event   = (w_sync_in & ~r_sync_prev & r_rise_en) |
                       (~w_sync_in & r_sync_prev & r_fall_en);

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            A_IN:     w_rdata = 32'(w_sync_in);
            A_OUT:    w_rdata = 32'(r_out);
            A_RISE:   w_rdata = 32'(r_rise_en);
            A_FALL:   w_rdata = 32'(r_fall_en);
            A_STATUS: w_rdata = 32'(r_status);
            A_IRQ_EN: w_rdata = 32'(r_irq_en);
            default:  w_rdata = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a coincident event survives the W1C.
    always_comb begin
        w_status_nxt = r_status | w_event;
        if (w_wr && (w_sel == A_STATUS))
            w_status_nxt = (r_status & ~IN_WIDTH'(w_wmask)) | w_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= '0;
            r_sync_prev <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_sync_prev <= w_sync_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_irq_en  <= '0;
        end else begin
            r_gnt    <= w_accept;
            r_rvalid <= r_gnt;
            r_status <= w_status_nxt;
            if (w_rd)
                r_rdata <= w_rdata;
            if (w_wr) begin
                case (w_sel)
                    A_OUT:    r_out     <= OUT_WIDTH'((32'(r_out) & ~w_bmask) | w_wmask);
                    A_SET:    r_out     <= OUT_WIDTH'(32'(r_out) | w_wmask);
                    A_CLR:    r_out     <= OUT_WIDTH'(32'(r_out) & ~w_wmask);
                    A_RISE:   r_rise_en <= IN_WIDTH'((32'(r_rise_en) & ~w_bmask) | w_wmask);
                    A_FALL:   r_fall_en <= IN_WIDTH'((32'(r_fall_en) & ~w_bmask) | w_wmask);
                    A_IRQ_EN: r_irq_en  <= IN_WIDTH'((32'(r_irq_en) & ~w_bmask) | w_wmask);
                    default:  ;
                endcase
            end
        end
    end

    assign data_gnt    = r_gnt;
    assign data_rvalid = r_rvalid;
    assign data_rdata  = r_rdata;
    assign gpio_out    = r_out;
    assign irq         = |(r_status & r_irq_en);

endmodule

// File: tb/tb_gpio_irq_controller.sv
// Randomised bench for gpio_irq_controller: a register-level model checked every cycle,
// plus directed cases with hand-computed values.
module tb_gpio_irq_controller;
    localparam int          OW   = 18;
    localparam int          IW   = 12;
    localparam int          SS   = 2;
    localparam logic [19:0] BASE = 20'h00001;
    localparam logic [31:0] OM   = 32'h0003_FFFF;
    localparam logic [31:0] IM   = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_req, data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_addr, data_wdata;
    logic          data_gnt, data_rvalid;
    logic [31:0]   data_rdata;
    logic [OW-1:0] gpio_out;
    logic [IW-1:0] gpio_in;
    logic          irq;

    gpio_irq_controller #(.OUT_WIDTH(OW), .IN_WIDTH(IW), .BASE_PAGE(BASE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: register contents as plain words, input pipeline as a sample queue.
    logic [31:0] m_out, m_rise, m_fall, m_status, m_irqen, m_rdata, m_sync, m_prev;
    bit          m_gnt, m_rvalid;
    logic [31:0] m_q[$];

    function automatic logic [31:0] m_read(input int off);
        case (off)
            0:       return m_sync;
            1:       return m_out;
            4:       return m_rise;
            5:       return m_fall;
            6:       return m_status;
            7:       return m_irqen;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = 0; m_rise = 0; m_fall = 0; m_status = 0; m_irqen = 0;
            m_rdata = 0; m_sync = 0; m_prev = 0; m_gnt = 0; m_rvalid = 0;
            m_q.delete();
            for (int i = 0; i < SS; i++) m_q.push_back(32'h0);
        end else begin : step
            logic [31:0] bm, wm, ev, clr;
            bit          acc;
            int          off;
            ev  = ((m_sync & ~m_prev & m_rise) | (~m_sync & m_prev & m_fall)) & IM;
            acc = data_req && (data_addr[31:12] == BASE) && !m_gnt;
            off = int'(data_addr[11:2]);
            bm  = {{8{data_be[3]}}, {8{data_be[2]}}, {8{data_be[1]}}, {8{data_be[0]}}};
            wm  = data_wdata & bm;
            clr = 32'h0;
            if (acc && !data_we) m_rdata = m_read(off);
            if (acc && data_we) begin
                case (off)
                    1: m_out   = ((m_out & ~bm) | wm) & OM;
                    2: m_out   = (m_out | wm) & OM;
                    3: m_out   = m_out & ~wm;
                    4: m_rise  = ((m_rise & ~bm) | wm) & IM;
                    5: m_fall  = ((m_fall & ~bm) | wm) & IM;
                    6: clr     = wm;
                    7: m_irqen = ((m_irqen & ~bm) | wm) & IM;
                    default: ;
                endcase
            end
            m_status = ((m_status & ~clr) | ev) & IM;
            m_rvalid = m_gnt;
            m_gnt    = acc;
            m_prev   = m_sync;
            m_q.push_back(32'(gpio_in));
            void'(m_q.pop_front());
            m_sync   = m_q[0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt",      32'(data_gnt),    32'(m_gnt));
            chk("rvalid",   32'(data_rvalid), 32'(m_rvalid));
            chk("rdata",    data_rdata,       m_rdata);
            chk("gpio_out", 32'(gpio_out),    m_out);
            chk("irq",      32'(irq),         32'(|(m_status & m_irqen)));
        end
    end

    logic        lg, lr0, lr;
    logic [31:0] lrd;

    // Starts just after a rising edge; the commit edge is the next one.
    task automatic bus(input bit we, input logic [3:0] be, input logic [9:0] off,
                       input logic [31:0] wd, input logic [19:0] pg = BASE);
        data_req = 1'b1; data_we = we; data_be = be; data_addr = {pg, off, 2'b00}; data_wdata = wd;
        @(posedge clk); #1;
        data_req = 1'b0; lg = data_gnt; lr0 = data_rvalid;
        @(posedge clk); #1;
        lr = data_rvalid; lrd = data_rdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0; gpio_in = 0;
        #1 rst = 1'b1;
        tick(3);
        chk("rst_gnt",  32'(data_gnt), 32'h0);
        chk("rst_rv",   32'(data_rvalid), 32'h0);
        chk("rst_out",  32'(gpio_out), 32'h0);
        chk("rst_irq",  32'(irq), 32'h0);
        rst = 1'b0;
        tick(1);

        // Byte-enabled OUT write and readback timing.
        bus(1, 4'b0101, 10'd1, 32'h0003_FFFF);
        chk("be_gnt", 32'(lg), 32'h1);
        chk("be_out", 32'(gpio_out), 32'h0003_00FF);
        bus(0, 4'hF, 10'd1, 32'h0);
        chk("rd_gnt", 32'(lg), 32'h1);
        chk("rd_rv_early", 32'(lr0), 32'h0);
        chk("rd_rv", 32'(lr), 32'h1);
        chk("rd_out", lrd, 32'h0003_00FF);

        // SET / CLR aliases.
        bus(1, 4'hF, 10'd1, 32'h0000_00F0);
        bus(1, 4'hF, 10'd2, 32'h0000_000F);
        bus(1, 4'hF, 10'd3, 32'h0000_0030);
        chk("setclr_out", 32'(gpio_out), 32'h0000_00CF);
        bus(0, 4'hF, 10'd2, 32'h0);
        chk("rd_set", lrd, 32'h0);
        bus(0, 4'hF, 10'd3, 32'h0);
        chk("rd_clr", lrd, 32'h0);

        // Rising edge -> STATUS/irq latency, then W1C.
        bus(1, 4'hF, 10'd6, 32'h0000_0FFF);
        bus(1, 4'hF, 10'd4, 32'h1);
        bus(1, 4'hF, 10'd7, 32'h1);
        gpio_in = 12'h001;
        tick(1); chk("irq_e1", 32'(irq), 32'h0);
        tick(1); chk("irq_e2", 32'(irq), 32'h0);
        tick(1); chk("irq_e3", 32'(irq), 32'h1);
        bus(0, 4'hF, 10'd6, 32'h0);
        chk("status_rd", lrd, 32'h1);
        bus(1, 4'hF, 10'd6, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);

        // W1C coincident with a new rising edge: the set wins.
        gpio_in = 12'h000;
        tick(4);
        gpio_in = 12'h001;
        tick(2);
        bus(1, 4'hF, 10'd6, 32'h1);
        chk("w1c_race_irq", 32'(irq), 32'h1);
        bus(0, 4'hF, 10'd6, 32'h0);
        chk("w1c_race_st", lrd, 32'h1);
        bus(1, 4'b1110, 10'd6, 32'h1);
        chk("w1c_be_off", 32'(irq), 32'h1);
        bus(1, 4'hF, 10'd6, 32'h1);
        chk("w1c_be_on", 32'(irq), 32'h0);

        // Wrong page and unmapped offset.
        bus(1, 4'hF, 10'd1, 32'hFFFF_FFFF, 20'h00002);
        chk("nodec_gnt", 32'(lg), 32'h0);
        chk("nodec_rv", 32'(lr), 32'h0);
        chk("nodec_out", 32'(gpio_out), 32'h0000_00CF);
        bus(0, 4'hF, 10'd8, 32'h0);
        chk("unmap_gnt", 32'(lg), 32'h1);
        chk("unmap_rd", lrd, 32'h0);

        // Held request -> alternate-cycle grants; async reset mid-stream.
        gpio_in = 12'hA5A;
        tick(3);
        data_req = 1; data_we = 0; data_be = 4'hF; data_addr = {BASE, 10'd0, 2'b00};
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("hold_gnt", 32'(data_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        tick(1);
        chk("pre_rst_rd", data_rdata, 32'h0000_0A5A);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(data_gnt), 32'h0);
        chk("arst_out", 32'(gpio_out), 32'h0);
        chk("arst_rd",  data_rdata, 32'h0);
        data_req = 0;
        tick(1);
        rst = 1'b0;
        tick(1);
        bus(1, 4'hF, 10'd1, 32'h55);
        chk("post_rst_gnt", 32'(lg), 32'h1);
        chk("post_rst_out", 32'(gpio_out), 32'h55);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            data_req   = ($urandom_range(0, 3) != 0);
            data_we    = 1'($urandom_range(0, 1));
            data_be    = 4'($urandom);
            data_addr  = {($urandom_range(0, 9) == 0) ? 20'($urandom) : BASE,
                          10'($urandom_range(0, 9)), 2'($urandom)};
            data_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(0, 3) == 0) gpio_in = IW'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick(1);
        end
        data_req = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
